// File: rtl/gray_pkg.sv
// Shared types and helpers for the gray-code sequence generator and its
// neighbouring binary/gray converter stage.
package gray_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int MAX_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Reflected binary code at the widest supported width; narrower users
  // zero-extend the input and keep the low bits.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_seq_gen_if.sv
// Stream and control bundle between the sequence generator and its user.
interface gray_seq_gen_if #(
  parameter int WIDTH = gray_pkg::DEF_WIDTH
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_out;
  logic             wrap;

  // Master drives control and consumes the stream.
  modport master (
    output en, up, load, load_bin, out_ready,
    input  out_valid, gray_out, bin_out, wrap
  );

  // Slave is the generator itself.
  modport slave (
    input  en, up, load, load_bin, out_ready,
    output out_valid, gray_out, bin_out, wrap
  );
endinterface

// File: rtl/gray_encode.sv
// Combinational binary-to-gray encoder, one XOR per bit; the MSB passes through.
module gray_encode #(
  parameter int WIDTH = gray_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray[WIDTH-1] = bin[WIDTH-1];

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_bit
    assign gray[i] = bin[i] ^ bin[i+1];
  end

endmodule

// File: rtl/gray_seq_gen.sv
// Gray-code stream source: up/down binary counter, registered gray encoding,
// valid/ready output with load override and wrap pulse.
module gray_seq_gen
  import gray_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  gray_seq_gen_if.slave   bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             hs;

  assign hs = (state_q == RUN) && bus.out_ready;

  // Next-state: load beats the handshake advance, which beats the en-driven
  // IDLE->RUN move; without a handshake in RUN everything holds.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    wrap_d  = 1'b0;
    if (bus.load) begin
      bin_d   = bus.load_bin;
      state_d = IDLE;
    end else if (hs) begin
      if (bus.up) begin
        bin_d  = bin_q + 1'b1;
        wrap_d = (bin_q == {WIDTH{1'b1}});
      end else begin
        bin_d  = bin_q - 1'b1;
        wrap_d = (bin_q == '0);
      end
      if (!bus.en) state_d = IDLE;
    end else if ((state_q == IDLE) && bus.en) begin
      state_d = RUN;
    end
  end

  // Encode the next count so gray and binary land on the same edge.
  gray_encode #(.WIDTH(WIDTH)) u_enc (
    .bin  (bin_d),
    .gray (gray_d)
  );

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      gray_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.out_valid = (state_q == RUN);
  assign bus.bin_out   = bin_q;
  assign bus.gray_out  = gray_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_gray_seq_gen.sv
// Scoreboard bench for gray_seq_gen at WIDTH=4: a cycle model predicts the
// outputs after every edge, a monitor compares them on the falling edge.
module tb_gray_seq_gen;

  localparam int W = 4;
  localparam int N = 1 << W;

  typedef struct {
    bit v;
    int b;
    int g;
    bit w;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  gray_seq_gen_if #(.WIDTH(W)) bus ();

  gray_seq_gen #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: count kept as an integer, advances done with plain
  // modular arithmetic, gray from the textbook formula.
  initial begin
    int  cnt;
    bit  run;
    bit  wr;
    int  nxt;
    exp_t e;
    cnt = 0; run = 0; wr = 0;
    forever begin
      @(posedge clk);
      wr = 0;
      if (rst) begin
        cnt = 0; run = 0;
      end else if (bus.load) begin
        cnt = int'(bus.load_bin); run = 0;
      end else if (run && bus.out_ready) begin
        nxt = cnt + (bus.up ? 1 : -1);
        wr  = (nxt < 0) || (nxt >= N);
        cnt = (nxt + N) % N;
        run = bus.en;
      end else if (!run && bus.en) begin
        run = 1;
      end
      e.v = run; e.b = cnt; e.g = cnt ^ (cnt >> 1); e.w = wr;
      exp_q.push_back(e);
    end
  end

  // Monitor: one expected record per edge, compared away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_valid", int'(bus.out_valid), int'(e.v));
        chk("bin_out",   int'(bus.bin_out),   e.b);
        chk("gray_out",  int'(bus.gray_out),  e.g);
        chk("wrap",      int'(bus.wrap),      int'(e.w));
      end
    end
  end

  task automatic cyc(input bit r, input bit e, input bit u, input bit l,
                     input logic [W-1:0] lb, input bit rd);
    @(negedge clk);
    rst = r; bus.en = e; bus.up = u; bus.load = l;
    bus.load_bin = lb; bus.out_ready = rd;
  endtask

  initial begin
    int gtab [9] = '{0, 1, 3, 2, 6, 7, 5, 4, 12};
    bus.en = 0; bus.up = 1; bus.load = 0; bus.load_bin = '0; bus.out_ready = 0;

    cyc(1, 0, 1, 0, 4'h0, 0);
    cyc(1, 0, 1, 0, 4'h0, 0);
    // Count up from reset: fixed gray sequence.
    cyc(0, 1, 1, 0, 4'h0, 1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("seq_gray", int'(bus.gray_out), gtab[i]);
      chk("seq_wrap", int'(bus.wrap), 0);
    end
    // Run through 15 -> 0 wrap, then count down across 0 -> 15.
    repeat (9) cyc(0, 1, 1, 0, 4'h0, 1);
    repeat (3) cyc(0, 1, 0, 0, 4'h0, 1);
    // Reach bin 6 then stall for 5 cycles, then resume.
    cyc(0, 1, 1, 0, 4'h0, 0);
    cyc(1, 0, 1, 0, 4'h0, 0);
    cyc(0, 1, 1, 0, 4'h0, 1);
    repeat (6) cyc(0, 1, 1, 0, 4'h0, 1);
    repeat (5) cyc(0, 1, 1, 0, 4'h0, 0);
    @(negedge clk);
    chk("stall_gray", int'(bus.gray_out), 4'b0101);
    chk("stall_valid", int'(bus.out_valid), 1);
    cyc(0, 1, 1, 0, 4'h0, 1);
    @(negedge clk);
    chk("resume_bin", int'(bus.bin_out), 7);
    // Stall then load 1010.
    cyc(0, 1, 1, 0, 4'h0, 0);
    cyc(0, 1, 1, 1, 4'b1010, 0);
    cyc(0, 1, 1, 0, 4'h0, 0);
    @(negedge clk);
    chk("load_bin", int'(bus.bin_out), 4'b1010);
    chk("load_gray", int'(bus.gray_out), 4'b1111);
    chk("load_valid", int'(bus.out_valid), 1);
    // Drop en while streaming, then raise it again.
    cyc(0, 1, 1, 0, 4'h0, 1);
    cyc(0, 0, 1, 0, 4'h0, 1);
    repeat (3) cyc(0, 0, 1, 0, 4'h0, 1);
    repeat (3) cyc(0, 1, 1, 0, 4'h0, 1);
    // Reset mid-stream with load and ready asserted.
    cyc(1, 1, 1, 1, 4'h9, 1);
    cyc(0, 1, 1, 0, 4'h0, 1);
    @(negedge clk);
    chk("rst_restart_gray", int'(bus.gray_out), 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
          $urandom_range(0, 1), ($urandom_range(0, 11) == 0),
          W'($urandom_range(0, N - 1)), ($urandom_range(0, 2) != 0));
    end
    cyc(0, 0, 1, 0, 4'h0, 1);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_seq_gen.md
# gray_seq_gen

Sequential gray-code source that sits directly upstream of the 4-bit binary-to-gray / gray-to-binary conversion stage. It holds a binary up/down counter, encodes it to gray code in registers, and presents each code word on a valid/ready stream. Downstream converter and checker logic consume it, so every word must be glitch-free and change only one bit per advance. Intended use: stimulus generator and position counter for the converter and multiplier test fabric.

## Interface
Parameters:
- WIDTH, 4: counter and code width in bits; legal range 2..16.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  level enable; 1 = stream runs, 0 = stop after the current word is accepted.
- up  in  1  direction, sampled at each advance; 1 = increment, 0 = decrement.
- load  in  1  single-cycle request to load load_bin.
- load_bin  in  WIDTH  binary value to load.
- out_ready  in  1  downstream accepts the word this cycle.
- out_valid  out  1  gray_out/bin_out hold a word for downstream.
- gray_out  out  WIDTH  registered gray code of the counter, bin ^ (bin >> 1).
- bin_out  out  WIDTH  registered binary counter value.
- wrap  out  1  one-cycle pulse when an advance crosses the boundary.

## Operation
- Two-state FSM:
  - IDLE: out_valid=0.
  - RUN: out_valid=1.
- Reset:
  - state=IDLE; bin_out=0; gray_out=0; out_valid=0; wrap=0.
- IDLE:
  - en=1 moves to RUN next cycle. The current count is presented unchanged and is not advanced on entry.
- RUN:
  - Handshake is out_valid && out_ready.
  - On a handshake, the count advances by ±1 per up, modulo 2^WIDTH. bin_out and gray_out update together on the same edge.
  - No handshake: bin_out and gray_out are held bit-stable, and en is ignored.
  - Handshake with en=0: the advance still happens and the state goes to IDLE.
- Wrap:
  - wrap=1 in the cycle after a handshake whose advance went 2^WIDTH−1 → 0 (up) or 0 → 2^WIDTH−1 (down). Otherwise wrap=0.
- Load:
  - load has priority over the handshake and the advance, in any state.
  - bin_out ← load_bin and gray_out ← encode(load_bin); state ← IDLE; wrap=0.
  - A word pending with out_valid && !out_ready is discarded. This is the only legal break of output stability.
- Priority: rst > load > handshake advance > en-driven state change.
- gray_out never depends combinationally on any input. Adjacent accepted words differ in exactly one gray bit, except across a load.

## Timing
- IDLE→RUN latency: en high at edge N gives out_valid=1 after edge N. The first word is the count held in IDLE.
- Throughput: one word per cycle while out_ready=1.
- Handshake at edge N: the new word is visible after N, and wrap (if any) is high for the cycle after N only.
- Load at edge N: out_valid=0 after N. If en=1, out_valid=1 after N+1 with the loaded value.
- Reset mid-stream takes effect at the next edge regardless of handshake, load or en.

## Structure
- Package gray_pkg:
  - WIDTH default constant.
  - state enum {IDLE, RUN}.
  - function bin2gray.
- Sub-module gray_encode: purely combinational, WIDTH-parameterised bin → gray. It feeds the output register so the encoder can be reused by the neighbouring converter stage.
- Top module: FSM, counter, output registers, wrap flag. Target 150–250 lines.

## Test plan
All scenarios use WIDTH=4.
- Reset then en=1, out_ready=1, up=1 → gray_out 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100 on successive cycles; wrap=0 throughout.
- Continue counting up through bin 15 (gray 1000) → next word is gray 0000 and wrap is high for exactly one cycle. Count down from bin 0 → bin 15 / gray 1000 with a wrap pulse.
- Stall: out_ready=0 for 5 cycles in RUN at bin 6 (gray 0101) → outputs constant and out_valid=1. After ready rises, the next word is bin 7 / gray 0100.
- Load load_bin=1010 while stalled → after the edge out_valid=0; after the next edge (en=1) bin_out=1010 and gray_out=1111. The discarded word never handshakes.
- en dropped while streaming → the last handshake still advances, then out_valid=0. Raising en again resumes from the advanced value.
- rst asserted for one cycle mid-stream with out_ready=1 and load=1 → outputs 0, out_valid=0, wrap=0 next cycle. The stream restarts at gray 0000.
